// File: rtl/fir_pkg.sv
// Shared types and constants for the FIR coefficient path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fir_pkg;

    // Coefficient / checksum width: signed, 4 fractional bits (16 = 1.0)
    localparam int CW         = 13;
    // Reset value of c0; with c1..c4 at zero the filter passes data through
    localparam int DEFAULT_C0 = 16;
    // Number of filter taps held in the shadow bank
    localparam int NTAPS      = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        CHECK  = 2'd2,
        COMMIT = 2'd3
    } state_t;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_CSUM = 2'b01;
    localparam logic [1:0] ERR_TMO  = 2'b10;

endpackage

// File: rtl/fir_coef_loader.sv
// Loads five signed coefficients plus checksum, commits all five atomically to c0..c4.
// Latency: coefficients and load_done update one cycle after the checksum is accepted.
// Backpressure: wr_ready high only while collecting a frame; words offered otherwise are dropped.
module fir_coef_loader #(
    parameter int CW         = fir_pkg::CW,
    parameter int TIMEOUT    = 64,
    parameter int DEFAULT_C0 = fir_pkg::DEFAULT_C0
) (
    input  logic                 clk20,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 wr_valid,
    input  logic signed [CW-1:0] wr_data,
    output logic                 wr_ready,
    output logic signed [CW-1:0] c0,
    output logic signed [CW-1:0] c1,
    output logic signed [CW-1:0] c2,
    output logic signed [CW-1:0] c3,
    output logic signed [CW-1:0] c4,
    output logic                 busy,
    output logic                 load_done,
    output logic                 err,
    output logic [1:0]           err_code
);
    import fir_pkg::*;

    // Idle-cycle timer; a zero TIMEOUT still needs a one-bit vector
    localparam int            TW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [2:0]    IDX_LAST = 3'(NTAPS - 1);

    state_t                state_q, state_d;
    logic [2:0]            idx_q, idx_d;
    logic signed [CW-1:0]  sum_q, sum_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic signed [CW-1:0]  shadow_q [NTAPS];
    logic signed [CW-1:0]  shadow_d [NTAPS];
    logic signed [CW-1:0]  c_q      [NTAPS];
    logic signed [CW-1:0]  c_d      [NTAPS];
    logic                  wr_ready_q, wr_ready_d;
    logic                  busy_q, busy_d;
    logic                  load_done_q, load_done_d;
    logic                  err_q, err_d;
    logic [1:0]            err_code_q, err_code_d;

    logic                  in_frame;
    logic                  accept;
    logic                  csum_ok;
    logic                  tmo_hit;

    // wr_ready_q is high exactly in LOAD/CHECK, so it doubles as the frame-active qualifier
    assign in_frame = wr_ready_q;
    assign accept   = wr_valid && wr_ready_q;
    assign csum_ok  = (wr_data == sum_q);
    // Fires on the TIMEOUT-th idle cycle; an acceptance or restart in that cycle wins
    assign tmo_hit  = (TIMEOUT > 0) && in_frame && !start && !accept && (timer_q == TMO_LAST);

    // State register
    always_ff @(posedge clk20) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: restart has priority, then acceptance, then timeout
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = LOAD;
            end
            LOAD: begin
                if (start)                             state_d = LOAD;
                else if (accept && idx_q == IDX_LAST)  state_d = CHECK;
                else if (tmo_hit)                      state_d = IDLE;
            end
            CHECK: begin
                if (start)        state_d = LOAD;
                else if (accept)  state_d = csum_ok ? COMMIT : IDLE;
                else if (tmo_hit) state_d = IDLE;
            end
            COMMIT: begin
                // start is ignored here; the commit always completes
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic: flags decoded from the next state plus one-cycle pulses and active bank
    always_comb begin
        wr_ready_d  = (state_d == LOAD) || (state_d == CHECK);
        busy_d      = (state_d != IDLE);
        load_done_d = 1'b0;
        err_d       = 1'b0;
        err_code_d  = err_code_q;
        c_d         = c_q;
        if (state_q == COMMIT) begin
            c_d         = shadow_q;
            load_done_d = 1'b1;
        end else if (in_frame && !start) begin
            if (accept && state_q == CHECK && !csum_ok) begin
                err_d      = 1'b1;
                err_code_d = ERR_CSUM;
            end else if (tmo_hit) begin
                err_d      = 1'b1;
                err_code_d = ERR_TMO;
            end
        end
    end

    // Frame datapath: shadow bank, running checksum, word index, idle timer
    always_comb begin
        idx_d    = idx_q;
        sum_d    = sum_q;
        timer_d  = timer_q;
        shadow_d = shadow_q;
        if (start && state_q != COMMIT) begin
            idx_d   = '0;
            sum_d   = '0;
            timer_d = '0;
            for (int i = 0; i < NTAPS; i++) shadow_d[i] = '0;
        end else if (in_frame) begin
            if (accept) begin
                timer_d = '0;
                if (state_q == LOAD) begin
                    shadow_d[idx_q] = wr_data;
                    sum_d           = sum_q + wr_data;
                    idx_d           = idx_q + 3'd1;
                end
            end else if (tmo_hit) begin
                timer_d = '0;
            end else begin
                timer_d = timer_q + 1'b1;
            end
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk20) begin
        if (!reset) begin
            idx_q       <= '0;
            sum_q       <= '0;
            timer_q     <= '0;
            wr_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            load_done_q <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= ERR_NONE;
            for (int i = 0; i < NTAPS; i++) begin
                shadow_q[i] <= '0;
                c_q[i]      <= (i == 0) ? CW'(DEFAULT_C0) : '0;
            end
        end else begin
            idx_q       <= idx_d;
            sum_q       <= sum_d;
            timer_q     <= timer_d;
            wr_ready_q  <= wr_ready_d;
            busy_q      <= busy_d;
            load_done_q <= load_done_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
            shadow_q    <= shadow_d;
            c_q         <= c_d;
        end
    end

    assign wr_ready  = wr_ready_q;
    assign busy      = busy_q;
    assign load_done = load_done_q;
    assign err       = err_q;
    assign err_code  = err_code_q;
    assign c0        = c_q[0];
    assign c1        = c_q[1];
    assign c2        = c_q[2];
    assign c3        = c_q[3];
    assign c4        = c_q[4];

endmodule

// File: tb/tb_fir_coef_loader.sv
// Bench for fir_coef_loader: directed frames plus randomized frames against a frame-level model.
// Latency: inputs driven and outputs sampled on the falling edge of clk20.
// Backpressure: words offered outside a frame are expected to be dropped.
module tb_fir_coef_loader;

    logic               clk20;
    logic               reset;
    logic               start;
    logic               wr_valid;
    logic signed [12:0] wr_data;
    logic               wr_ready;
    logic signed [12:0] c0, c1, c2, c3, c4;
    logic               busy;
    logic               load_done;
    logic               err;
    logic [1:0]         err_code;

    fir_coef_loader dut (
        .clk20     (clk20),
        .reset     (reset),
        .start     (start),
        .wr_valid  (wr_valid),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .c0        (c0),
        .c1        (c1),
        .c2        (c2),
        .c3        (c3),
        .c4        (c4),
        .busy      (busy),
        .load_done (load_done),
        .err       (err),
        .err_code  (err_code)
    );

    initial clk20 = 1'b0;
    always #25 clk20 = ~clk20;

    // Reference state: active coefficients and last error code
    logic signed [12:0] model_c [5];
    logic [1:0]         model_code;
    // Frame under test: five words plus checksum, and idle gaps before each
    logic signed [12:0] fw [6];
    int                 fg [6];

    int passes = 0;
    int total  = 0;

    task automatic step();
        @(negedge clk20);
    endtask

    task automatic chkb(input string tag, input logic got, input logic exp);
        total++;
        assert (got === exp) passes++;
        else $error("FAIL %s got=%0b exp=%0b", tag, got, exp);
    endtask

    task automatic chkw(input string tag, input logic [12:0] got, input logic [12:0] exp);
        total++;
        assert (got === exp) passes++;
        else $error("FAIL %s got=%0d exp=%0d", tag, $signed(got), $signed(exp));
    endtask

    task automatic chk_coefs(input string tag);
        chkw({tag, "_c0"}, c0, model_c[0]);
        chkw({tag, "_c1"}, c1, model_c[1]);
        chkw({tag, "_c2"}, c2, model_c[2]);
        chkw({tag, "_c3"}, c3, model_c[3]);
        chkw({tag, "_c4"}, c4, model_c[4]);
    endtask

    task automatic model_reset();
        model_c[0] = 13'sd16;
        for (int i = 1; i < 5; i++) model_c[i] = '0;
        model_code = 2'b00;
    endtask

    // Plays fw/fg as one frame (start with a junk word alongside) and checks the outcome
    task automatic do_frame(input string tag);
        int s;
        bit ok;
        s = 0;
        for (int i = 0; i < 5; i++) s += int'(fw[i]);
        ok = ((s & 8191) == (int'(fw[5]) & 8191));
        start    = 1'b1;
        wr_valid = 1'b1;
        wr_data  = 13'sh0aa5;
        step();
        start = 1'b0;
        chkb({tag, "_ready"}, wr_ready, 1'b1);
        for (int i = 0; i < 6; i++) begin
            wr_valid = 1'b0;
            repeat (fg[i]) step();
            wr_valid = 1'b1;
            wr_data  = fw[i];
            step();
        end
        wr_valid = 1'b0;
        if (ok) begin
            chkb({tag, "_commit_busy"}, busy, 1'b1);
            chkb({tag, "_commit_ld_early"}, load_done, 1'b0);
            chk_coefs({tag, "_before"});
            step();
            for (int i = 0; i < 5; i++) model_c[i] = fw[i];
            chkb({tag, "_load_done"}, load_done, 1'b1);
            chkb({tag, "_busy_drop"}, busy, 1'b0);
            chkb({tag, "_no_err"}, err, 1'b0);
            chk_coefs({tag, "_after"});
            step();
            chkb({tag, "_ld_pulse"}, load_done, 1'b0);
        end else begin
            model_code = 2'b01;
            chkb({tag, "_err"}, err, 1'b1);
            chkb({tag, "_err_busy"}, busy, 1'b0);
            chkw({tag, "_err_code"}, 13'(err_code), 13'(model_code));
            chk_coefs({tag, "_kept"});
            step();
            chkb({tag, "_err_pulse"}, err, 1'b0);
            chkw({tag, "_code_held"}, 13'(err_code), 13'(model_code));
        end
    endtask

    task automatic set_frame(input int a, input int b, input int c, input int d,
                             input int e, input int cs);
        fw[0] = 13'(a); fw[1] = 13'(b); fw[2] = 13'(c);
        fw[3] = 13'(d); fw[4] = 13'(e); fw[5] = 13'(cs);
        for (int i = 0; i < 6; i++) fg[i] = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        wr_valid = 1'b0;
        wr_data  = '0;
        model_reset();
        repeat (3) step();
        reset = 1'b1;
        step();

        // Reset state
        chk_coefs("rst");
        chkb("rst_busy", busy, 1'b0);
        chkb("rst_ready", wr_ready, 1'b0);
        chkb("rst_ld", load_done, 1'b0);
        chkb("rst_err", err, 1'b0);
        chkw("rst_code", 13'(err_code), 13'(model_code));

        // Words offered while idle are dropped
        wr_valid = 1'b1;
        wr_data  = 13'sd99;
        repeat (3) step();
        wr_valid = 1'b0;
        chkb("idle_drop_busy", busy, 1'b0);
        chk_coefs("idle_drop");

        // Basic back-to-back frame
        set_frame(1, 2, 3, 4, 5, 15);
        do_frame("basic");

        // Signed wrap frame, then a bad checksum that must not disturb it
        set_frame(-16, 32, 64, 32, -16, 96);
        do_frame("signed");
        set_frame(7, 7, 7, 7, 7, 34);
        do_frame("badcs");

        // Timeout after two words
        start = 1'b1;
        step();
        start    = 1'b0;
        wr_valid = 1'b1;
        wr_data  = 13'sd3;
        repeat (2) step();
        wr_valid = 1'b0;
        repeat (63) step();
        chkb("tmo_not_yet", err, 1'b0);
        chkb("tmo_busy_yet", busy, 1'b1);
        step();
        model_code = 2'b10;
        chkb("tmo_err", err, 1'b1);
        chkw("tmo_code", 13'(err_code), 13'(model_code));
        chkb("tmo_idle", busy, 1'b0);
        chkb("tmo_ready", wr_ready, 1'b0);
        chk_coefs("tmo");

        // Word arriving on the last idle cycle before timeout is accepted
        set_frame(2, 4, 6, 8, 10, 30);
        fg[2] = 63;
        do_frame("tmo_edge");

        // Restart mid-frame
        start = 1'b1;
        step();
        start    = 1'b0;
        wr_valid = 1'b1;
        wr_data  = 13'sd100;
        repeat (3) step();
        wr_valid = 1'b0;
        set_frame(9, 0, 0, 0, 0, 9);
        do_frame("restart");

        // Reset in the middle of a frame
        start = 1'b1;
        step();
        start    = 1'b0;
        wr_valid = 1'b1;
        wr_data  = 13'sd50;
        repeat (4) step();
        wr_valid = 1'b0;
        reset    = 1'b0;
        step();
        reset = 1'b1;
        model_reset();
        step();
        chk_coefs("midrst");
        chkb("midrst_busy", busy, 1'b0);
        chkb("midrst_ready", wr_ready, 1'b0);
        chkb("midrst_err", err, 1'b0);
        chkw("midrst_code", 13'(err_code), 13'(model_code));
        set_frame(-1, -2, -3, -4, -5, -15);
        do_frame("postrst");

        // Randomized frames with gaps, some with corrupted checksums
        for (int n = 0; n < 12; n++) begin
            int s;
            s = 0;
            for (int i = 0; i < 5; i++) begin
                fw[i] = 13'($urandom);
                s += int'(fw[i]);
            end
            if ($urandom_range(0, 3) == 0) s += int'($urandom_range(1, 4000));
            fw[5] = 13'(s);
            for (int i = 0; i < 6; i++) fg[i] = int'($urandom_range(0, 3));
            do_frame("rand");
            wr_valid = 1'b1;
            repeat ($urandom_range(1, 3)) begin
                wr_data = 13'($urandom);
                step();
            end
            wr_valid = 1'b0;
            chkb("rand_idle_busy", busy, 1'b0);
            chk_coefs("rand_idle");
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

// File: doc/fir_coef_loader.md
# fir_coef_loader

Coefficient loader feeding the five-tap folded FIR filter's c0..c4 inputs. Accepts a framed stream of five 13-bit signed coefficients plus a checksum over a valid/ready interface. Holds them in a shadow bank and commits all five atomically to the active outputs only when the checksum matches. The filter therefore never sees a partially updated coefficient set. Runs on clk20; clk100 is edge-aligned and derived from the same source, so the outputs feed the filter's coefficient registers directly.

## Interface
- CW, 13, coefficient and checksum width (signed, 4 fractional bits; 16 = 1.0)
- TIMEOUT, 64, max idle cycles between accepted words inside a frame; 0 disables the timeout
- DEFAULT_C0, 16, reset value of c0 (c1..c4 reset to 0, giving unity pass-through)

Ports:
- clk20  in  1  clock
- reset  in  1  synchronous, active-low
- start  in  1  one-cycle frame start request
- wr_valid  in  1  wr_data valid
- wr_data  in  CW  coefficient word or checksum (signed)
- wr_ready  out  1  loader accepts wr_data this cycle
- c0, c1, c2, c3, c4  out  CW each  active coefficients, registered
- busy  out  1  state is not IDLE
- load_done  out  1  one-cycle pulse: new set committed
- err  out  1  one-cycle pulse: frame discarded
- err_code  out  2  01 = checksum mismatch, 10 = timeout; held until the next err

## Operation
- States:
  - IDLE: wr_ready=0. start moves to LOAD; idx=0, shadow cleared, sum=0, timer=0.
  - LOAD: wr_ready=1. Each accepted word (wr_valid&&wr_ready) goes to shadow[idx]; sum += word, wrapping mod 2^CW. After idx 4, go to CHECK.
  - CHECK: wr_ready=1. The accepted word is compared with sum. Match goes to COMMIT. Mismatch goes to IDLE with err=1, err_code=01.
  - COMMIT: wr_ready=0, one cycle. c0..c4 load shadow[0..4]; load_done=1; go to IDLE.
- start in LOAD or CHECK restarts the frame: back to idx 0, shadow and sum cleared, no err. start in COMMIT is ignored.
- Timeout: timer counts cycles in LOAD/CHECK without an acceptance and clears on acceptance or start. When timer reaches TIMEOUT, go to IDLE with err=1, err_code=10, frame discarded.
- An acceptance in the same cycle as the timer hitting TIMEOUT: the acceptance wins and there is no timeout.
- c0..c4 change only on the COMMIT edge. Failed or aborted frames never disturb them.
- wr_data with wr_valid while wr_ready=0 is dropped, not buffered.
- Reset:
  - state IDLE
  - c0=DEFAULT_C0, c1..c4=0
  - wr_ready=0, busy=0, load_done=0, err=0, err_code=00
  - shadow, sum and timer cleared
  - Reset mid-frame discards the frame with no err.

## Timing
- start at edge S: LOAD from S+1, wr_ready=1 in the cycle after S. A word presented together with start is not accepted.
- Minimum frame is 7 cycles: start, 5 words, checksum. With wr_valid held high, checksum is accepted at edge S+6.
- Checksum accepted at edge N (match): COMMIT during N..N+1. c0..c4 and load_done update at edge N+1; load_done is high for one cycle. busy drops at N+1.
- Mismatch at edge N: err high for the cycle after N; state IDLE after N.
- Timeout: err asserts the cycle after the TIMEOUT-th consecutive non-accepting cycle.
- All outputs are registered; there is no combinational path from inputs to outputs. wr_ready depends on state only.

## Structure
- Shared package fir_pkg:
  - CW
  - state enum {IDLE, LOAD, CHECK, COMMIT}
  - err code constants ERR_CSUM=2'b01, ERR_TMO=2'b10
  - DEFAULT_C0
- Single module, no sub-module. Shadow bank as a 5-entry array; timer width $clog2(TIMEOUT+1).

## Test plan
- Reset release, no traffic: c0=16, c1..c4=0, busy=0, wr_ready=0, err_code=00.
- start, then words 1,2,3,4,5 with checksum 15 back-to-back: load_done at edge S+7 (one after the checksum edge S+6), c0..c4=1,2,3,4,5, err never asserts.
- Words -16,32,64,32,-16 with checksum 96 (signed wrap check); then a second frame 7,7,7,7,7 with checksum 34 (35 expected): err pulse with err_code=01, c0..c4 stay -16,32,64,32,-16.
- start, two words, then wr_valid low for 64 cycles: err with err_code=10 and state IDLE. A word at cycle 63 (TIMEOUT=64) is accepted instead, with no err.
- start, three words, start again, then 9,0,0,0,0 with checksum 9: commit of 9,0,0,0,0 with no err.
- reset asserted after the fourth word: outputs return to defaults; a following full valid frame commits normally.
